// File: rtl/npc_lsu_pkg.sv
// rtl/npc_lsu_pkg.sv - shared types and helpers for the NPC load/store unit
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BUS      = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS_REQ = 2'd1,
    ST_BUS_RSP = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Natural alignment check; a dword access is never legal on a 32-bit datapath.
  function automatic logic is_misaligned(input size_e size, input logic [2:0] addr_lo,
                                         input logic xlen64);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo[1:0];
      default: return !xlen64 || (|addr_lo);
    endcase
  endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// rtl/npc_lsu_align.sv - byte-lane steering for stores and lane extraction for loads
module npc_lsu_align
  import npc_lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  size_e                 st_size_i,
  input  logic [OFF_W-1:0]      st_off_i,
  input  logic [XLEN-1:0]       st_data_i,
  output logic [XLEN-1:0]       st_data_o,
  output logic [XLEN/8-1:0]     st_strb_o,
  input  size_e                 ld_size_i,
  input  logic                  ld_unsigned_i,
  input  logic [OFF_W-1:0]      ld_off_i,
  input  logic [XLEN-1:0]       ld_data_i,
  output logic [XLEN-1:0]       ld_data_o
);

  localparam int STRB_W = XLEN / 8;

  logic [STRB_W-1:0] base_strb;
  logic [XLEN-1:0]   ld_shift;
  logic [XLEN-1:0]   ld_mask;
  logic              ld_sign;

  // Store side: 2^size contiguous strobes and data moved up to the lane offset.
  always_comb begin
    base_strb = '0;
    unique case (st_size_i)
      SZ_B: base_strb = STRB_W'(8'h01);
      SZ_H: base_strb = STRB_W'(8'h03);
      SZ_W: base_strb = STRB_W'(8'h0F);
      SZ_D: base_strb = STRB_W'(8'hFF);
    endcase
    st_strb_o = base_strb << st_off_i;
    st_data_o = st_data_i << {st_off_i, 3'b000};
  end

  // Load side: bring the addressed lane down, mask to size, then fill the upper bits
  // with the sign bit unless zero-extension is requested. A full-width access has an
  // all-ones mask, so extension has no effect there (word loads on XLEN = 32).
  always_comb begin
    ld_shift = ld_data_i >> {ld_off_i, 3'b000};
    ld_mask  = '1;
    ld_sign  = 1'b0;
    unique case (ld_size_i)
      SZ_B: begin ld_mask = XLEN'(8'hFF);         ld_sign = ld_shift[7];      end
      SZ_H: begin ld_mask = XLEN'(16'hFFFF);      ld_sign = ld_shift[15];     end
      SZ_W: begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = ld_shift[31];     end
      SZ_D: begin ld_mask = '1;                   ld_sign = ld_shift[XLEN-1]; end
    endcase
    ld_data_o = (ld_shift & ld_mask) | ((ld_sign && !ld_unsigned_i) ? ~ld_mask : '0);
  end

endmodule

// File: rtl/npc_lsu.sv
// rtl/npc_lsu.sv - single-outstanding load/store unit between execute and data bus
module npc_lsu
  import npc_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [XLEN-1:0]     mem_req_wdata,
  output logic [XLEN/8-1:0]   mem_req_wstrb,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [XLEN-1:0]     mem_rsp_rdata,
  input  logic                mem_rsp_err
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  logic                wen_q, wen_d;
  size_e               size_q, size_d;
  logic                uns_q, uns_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                mwen_q, mwen_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [XLEN-1:0]     mwdata_q, mwdata_d;
  logic [STRB_W-1:0]   mwstrb_q, mwstrb_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  err_e                err_q, err_d;

  logic [XLEN-1:0]     st_data;
  logic [STRB_W-1:0]   st_strb;
  logic [XLEN-1:0]     ld_data;

  npc_lsu_align #(.XLEN(XLEN)) u_align (
    .st_size_i     (size_e'(req_size)),
    .st_off_i      (req_addr[OFF_W-1:0]),
    .st_data_i     (req_wdata),
    .st_data_o     (st_data),
    .st_strb_o     (st_strb),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_off_i      (off_q),
    .ld_data_i     (mem_rsp_rdata),
    .ld_data_o     (ld_data)
  );

  // Next-state and datapath: the bus payload is computed at accept so that every
  // mem_* output is a register with no path back to the req_* inputs.
  always_comb begin
    state_d  = state_q;
    wen_d    = wen_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    mwen_d   = mwen_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwstrb_d = mwstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_inc  = cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d    = req_wen;
          size_d   = size_e'(req_size);
          uns_d    = req_unsigned;
          off_d    = req_addr[OFF_W-1:0];
          mwen_d   = req_wen;
          maddr_d  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
          mwdata_d = st_data;
          mwstrb_d = req_wen ? st_strb : '0;
          cnt_d    = '0;
          if (is_misaligned(size_e'(req_size), req_addr[2:0], XLEN == 64)) begin
            state_d = ST_RESP;
            err_d   = ERR_MISALIGN;
            rdata_d = '0;
          end else begin
            state_d = ST_BUS_REQ;
          end
        end
      end
      ST_BUS_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_BUS_RSP;
        end else begin
          cnt_d = cnt_inc;
          if (TIMEOUT != 0 && cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d = ST_RESP;
            err_d   = ERR_TIMEOUT;
            rdata_d = '0;
          end
        end
      end
      ST_BUS_RSP: begin
        if (mem_rsp_valid) begin
          state_d = ST_RESP;
          if (mem_rsp_err) begin
            err_d   = ERR_BUS;
            rdata_d = '0;
          end else begin
            err_d   = ERR_OK;
            rdata_d = wen_q ? '0 : ld_data;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  // State and payload registers; reset abandons any in-flight bus access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wen_q    <= 1'b0;
      size_q   <= SZ_B;
      uns_q    <= 1'b0;
      off_q    <= '0;
      cnt_q    <= '0;
      mwen_q   <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwstrb_q <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      mwen_q   <= mwen_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwstrb_q <= mwstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign mem_req_valid = (state_q == ST_BUS_REQ);
  assign mem_rsp_ready = (state_q == ST_BUS_RSP);
  assign rsp_valid     = (state_q == ST_RESP);
  assign mem_req_wen   = mwen_q;
  assign mem_req_addr  = maddr_q;
  assign mem_req_wdata = mwdata_q;
  assign mem_req_wstrb = mwstrb_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;

endmodule

// File: tb/tb_npc_lsu.sv
// tb/tb_npc_lsu.sv - scoreboard bench for npc_lsu on 32-bit and 64-bit instances
module tb_npc_lsu;

  typedef struct {
    logic [63:0] rdata;
    logic [1:0]  err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst_a, rst_b;
  logic        req_valid_a, req_valid_b;
  logic        req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_ready, mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic [63:0] mem_rsp_rdata;

  logic        req_ready_a, rsp_valid_a, mem_req_valid_a, mem_req_wen_a, mem_rsp_ready_a;
  logic [31:0] rsp_rdata_a, mem_req_addr_a, mem_req_wdata_a;
  logic [1:0]  rsp_err_a;
  logic [3:0]  mem_req_wstrb_a;

  logic        req_ready_b, rsp_valid_b, mem_req_valid_b, mem_req_wen_b, mem_rsp_ready_b;
  logic [63:0] rsp_rdata_b, mem_req_wdata_b;
  logic [31:0] mem_req_addr_b;
  logic [1:0]  rsp_err_b;
  logic [7:0]  mem_req_wstrb_b;

  npc_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(rst_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .mem_req_valid(mem_req_valid_a), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen_a),
    .mem_req_addr(mem_req_addr_a), .mem_req_wdata(mem_req_wdata_a), .mem_req_wstrb(mem_req_wstrb_a),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready_a),
    .mem_rsp_rdata(mem_rsp_rdata[31:0]), .mem_rsp_err(mem_rsp_err)
  );

  npc_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) dut_b (
    .clk(clk), .reset(rst_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .mem_req_valid(mem_req_valid_b), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen_b),
    .mem_req_addr(mem_req_addr_b), .mem_req_wdata(mem_req_wdata_b), .mem_req_wstrb(mem_req_wstrb_b),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready_b),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  logic        sel;
  logic        v_req_ready, v_rsp_valid, v_mem_req_valid;
  logic [31:0] v_mem_addr;
  logic [63:0] v_mem_wdata;
  logic [7:0]  v_mem_strb;
  assign v_req_ready     = sel ? req_ready_b     : req_ready_a;
  assign v_rsp_valid     = sel ? rsp_valid_b     : rsp_valid_a;
  assign v_mem_req_valid = sel ? mem_req_valid_b : mem_req_valid_a;
  assign v_mem_addr      = sel ? mem_req_addr_b  : mem_req_addr_a;
  assign v_mem_wdata     = sel ? mem_req_wdata_b : {32'd0, mem_req_wdata_a};
  assign v_mem_strb      = sel ? mem_req_wstrb_b : {4'd0, mem_req_wstrb_a};

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitors: every cycle a response is presented it must match the head
  // of the scoreboard; the entry is retired only when the handshake completes.
  always @(negedge clk) begin
    if (!rst_a && rsp_valid_a) begin
      if (q_a.size() == 0) check("rsp_a unexpected", 64'd1, 64'd0);
      else begin
        check("rsp_a rdata", {32'd0, rsp_rdata_a}, q_a[0].rdata);
        check("rsp_a err", {62'd0, rsp_err_a}, {62'd0, q_a[0].err});
        if (rsp_ready) void'(q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && rsp_valid_b) begin
      if (q_b.size() == 0) check("rsp_b unexpected", 64'd1, 64'd0);
      else begin
        check("rsp_b rdata", rsp_rdata_b, q_b[0].rdata);
        check("rsp_b err", {62'd0, rsp_err_b}, {62'd0, q_b[0].err});
        if (rsp_ready) void'(q_b.pop_front());
      end
    end
  end

  task automatic access(input bit b, input string name,
                        input logic wen, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [63:0] wdata,
                        input logic [63:0] bus_rdata, input logic bus_err, input logic mready,
                        input logic [63:0] exp_rdata, input logic [1:0] exp_err,
                        input int exp_lat, input int exp_memcyc,
                        input logic [31:0] exp_maddr, input logic [63:0] exp_mwdata,
                        input logic [7:0] exp_mstrb, input int hold);
    int          lat;
    int          memcyc;
    logic [31:0] maddr;
    logic [63:0] mwd;
    logic [7:0]  mstrb;
    exp_t        e;
    maddr = '0; mwd = '0; mstrb = '0;
    @(posedge clk); #1;
    sel = b;
    req_wen = wen; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    mem_rsp_rdata = bus_rdata; mem_rsp_err = bus_err; mem_req_ready = mready;
    mem_rsp_valid = 1'b1;
    rsp_ready = (hold == 0);
    check({name, " req_ready idle"}, {63'd0, v_req_ready}, 64'd1);
    e.rdata = exp_rdata; e.err = exp_err;
    if (b) begin req_valid_b = 1'b1; q_b.push_back(e); end
    else   begin req_valid_a = 1'b1; q_a.push_back(e); end
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    lat = 1; memcyc = 0;
    while (!v_rsp_valid && lat < 40) begin
      if (v_mem_req_valid) begin
        memcyc++;
        maddr = v_mem_addr; mwd = v_mem_wdata; mstrb = v_mem_strb;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " mem_req cycles"}, 64'(memcyc), 64'(exp_memcyc));
    if (exp_memcyc > 0) begin
      check({name, " mem_req_addr"}, {32'd0, maddr}, {32'd0, exp_maddr});
      check({name, " mem_req_wdata"}, mwd, exp_mwdata);
      check({name, " mem_req_wstrb"}, {56'd0, mstrb}, {56'd0, exp_mstrb});
    end
    repeat (hold) begin
      @(posedge clk); #1;
      check({name, " rsp_valid held"}, {63'd0, v_rsp_valid}, 64'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({name, " back to idle"}, {63'd0, v_req_ready}, 64'd1);
  endtask

  task automatic check_reset_a(input string name);
    check({name, " req_ready"}, {63'd0, req_ready_a}, 64'd1);
    check({name, " rsp_valid"}, {63'd0, rsp_valid_a}, 64'd0);
    check({name, " rsp_rdata"}, {32'd0, rsp_rdata_a}, 64'd0);
    check({name, " rsp_err"}, {62'd0, rsp_err_a}, 64'd0);
    check({name, " mem_req_valid"}, {63'd0, mem_req_valid_a}, 64'd0);
    check({name, " mem_req_wen"}, {63'd0, mem_req_wen_a}, 64'd0);
    check({name, " mem_req_addr"}, {32'd0, mem_req_addr_a}, 64'd0);
    check({name, " mem_req_wdata"}, {32'd0, mem_req_wdata_a}, 64'd0);
    check({name, " mem_req_wstrb"}, {60'd0, mem_req_wstrb_a}, 64'd0);
    check({name, " mem_rsp_ready"}, {63'd0, mem_rsp_ready_a}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    sel = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_err = 1'b0;
    mem_rsp_rdata = '0;
    #1;
    check_reset_a("reset");
    check("reset_b req_ready", {63'd0, req_ready_b}, 64'd1);
    check("reset_b mem_req_wstrb", {56'd0, mem_req_wstrb_b}, 64'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    //       b  name     wen size uns addr          wdata                  bus rdata               err rdy exp rdata               err lat mc maddr         mwdata                 strb  hold
    access(0, "lb",      0, 2'd0, 0, 32'h8000_0003, 64'h0,                 64'h80FF_1234,          0,  1,  64'hFFFF_FF80,          0,  3,  1, 32'h8000_0000, 64'h0,                 8'h0, 0);
    access(0, "sh",      1, 2'd1, 0, 32'h8000_0002, 64'h0000_ABCD,         64'hDEAD_BEEF,          0,  1,  64'h0,                  0,  3,  1, 32'h8000_0000, 64'hABCD_0000,         8'hC, 0);
    access(0, "lw_mis",  0, 2'd2, 0, 32'h8000_0001, 64'h0,                 64'h0,                  0,  1,  64'h0,                  1,  1,  0, 32'h0,         64'h0,                 8'h0, 0);
    access(0, "ld_32",   0, 2'd3, 0, 32'h8000_0000, 64'h0,                 64'h0,                  0,  1,  64'h0,                  1,  1,  0, 32'h0,         64'h0,                 8'h0, 0);
    access(0, "timeout", 0, 2'd2, 0, 32'h0000_0010, 64'h0,                 64'h1234_5678,          0,  0,  64'h0,                  3,  5,  4, 32'h0000_0010, 64'h0,                 8'h0, 0);
    access(0, "lhu",     0, 2'd1, 1, 32'h0000_0002, 64'h0,                 64'h80FF_1234,          0,  1,  64'h0000_80FF,          0,  3,  1, 32'h0,         64'h0,                 8'h0, 0);
    access(0, "lbu_hold",0, 2'd0, 1, 32'h0000_0001, 64'h0,                 64'h80FF_1234,          0,  1,  64'h0000_0012,          0,  3,  1, 32'h0,         64'h0,                 8'h0, 3);
    access(0, "lw_u32",  0, 2'd2, 1, 32'h0000_0004, 64'h0,                 64'h80FF_1234,          0,  1,  64'h80FF_1234,          0,  3,  1, 32'h4,         64'h0,                 8'h0, 0);
    access(0, "sw",      1, 2'd2, 0, 32'h0000_0008, 64'h1122_3344,         64'h0,                  0,  1,  64'h0,                  0,  3,  1, 32'h8,         64'h1122_3344,         8'hF, 0);
    access(0, "lh_berr", 0, 2'd1, 0, 32'h0000_0002, 64'h0,                 64'hFFFF_FFFF,          1,  1,  64'h0,                  2,  3,  1, 32'h0,         64'h0,                 8'h0, 0);
    access(1, "lw64",    0, 2'd2, 0, 32'h0000_0004, 64'h0,                 64'h8000_0001_0000_0000, 0, 1,  64'hFFFF_FFFF_8000_0001, 0, 3,  1, 32'h0,         64'h0,                 8'h0, 0);
    access(1, "lw64_err",0, 2'd2, 0, 32'h0000_0004, 64'h0,                 64'h8000_0001_0000_0000, 1, 1,  64'h0,                  2,  3,  1, 32'h0,         64'h0,                 8'h0, 0);
    access(1, "lwu64",   0, 2'd2, 1, 32'h0000_0004, 64'h0,                 64'h8000_0001_0000_0000, 0, 1,  64'h0000_0000_8000_0001, 0, 3,  1, 32'h0,         64'h0,                 8'h0, 0);
    access(1, "ld64",    0, 2'd3, 0, 32'h0000_0008, 64'h0,                 64'h0123_4567_89AB_CDEF, 0, 1,  64'h0123_4567_89AB_CDEF, 0, 3,  1, 32'h8,         64'h0,                 8'h0, 0);
    access(1, "sb64",    1, 2'd0, 0, 32'h0000_0005, 64'hAA,                64'h0,                  0,  1,  64'h0,                  0,  3,  1, 32'h0,         64'h0000_AA00_0000_0000, 8'h20, 0);
    access(1, "lw64_mis",0, 2'd2, 0, 32'h0000_0002, 64'h0,                 64'h0,                  0,  1,  64'h0,                  1,  1,  0, 32'h0,         64'h0,                 8'h0, 0);

    // Reset while waiting in BUS_RSP: the access is abandoned with no response.
    @(posedge clk); #1;
    sel = 1'b0;
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    req_wen = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0000_0020;
    req_wdata = 64'h5555_AAAA;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    cyc = 0;
    while (!mem_rsp_ready_a && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort reached BUS_RSP", {63'd0, mem_rsp_ready_a}, 64'd1);
    check("abort mem_req_addr", {32'd0, mem_req_addr_a}, 64'h20);
    #2;
    rst_a = 1'b1;
    #1;
    check_reset_a("abort reset");
    @(posedge clk); #1;
    rst_a = 1'b0;
    mem_rsp_valid = 1'b1;
    @(posedge clk); #1;
    check("abort idle after reset", {63'd0, req_ready_a}, 64'd1);
    check("abort no response", {63'd0, rsp_valid_a}, 64'd0);

    access(0, "lw_after", 0, 2'd2, 0, 32'h0000_0000, 64'h0, 64'hCAFE_F00D, 0, 1, 64'hCAFE_F00D, 0, 3, 1, 32'h0, 64'h0, 8'h0, 0);

    check("scoreboard a drained", 64'(q_a.size()), 64'd0);
    check("scoreboard b drained", 64'(q_b.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_lsu.md
# npc_lsu

Parametrised load/store unit for the NPC core, generalising the single-cycle memory path to XLEN 32/64 with byte/half/word/dword accesses. It sits between the execute stage and the data-memory bus. It accepts one access at a time over a valid/ready request channel and drives a handshaked memory bus that may take any number of cycles. It returns lane-extracted, sign- or zero-extended load data, plus an error code for misaligned, bus-error and timeout conditions.

## Interface
- XLEN, 32, data width; 32 or 64
- ADDR_W, 32, address width
- TIMEOUT, 255, maximum cycles waiting for mem_req_ready; 0 disables the timeout
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- req_valid / req_ready  in / out  1  request handshake from the execute stage
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- rsp_valid / rsp_ready  out / in  1  response handshake to the execute stage
- rsp_rdata  out  XLEN  extended load data; 0 for stores and on error
- rsp_err  out  2  0 ok, 1 misaligned, 2 bus error, 3 timeout
- mem_req_valid / mem_req_ready  out / in  1  bus request handshake
- mem_req_wen  out  1  bus write enable
- mem_req_addr  out  ADDR_W  req_addr with the low log2(XLEN/8) bits cleared
- mem_req_wdata  out  XLEN  store data shifted into its byte lanes
- mem_req_wstrb  out  XLEN/8  byte strobes; all 0 for loads
- mem_rsp_valid / mem_rsp_ready  in / out  1  bus response handshake
- mem_rsp_rdata  in  XLEN  full-width bus read data
- mem_rsp_err  in  1  bus error flag

## Operation
The unit is an FSM with four states: IDLE, BUS_REQ, BUS_RSP, RESP.

- **IDLE**
  - req_ready = 1.
  - On req_valid, latch wen, size, unsigned, addr and wdata.
  - An access is misaligned when addr mod 2^size ≠ 0, or when size = 3 with XLEN = 32. A misaligned access goes to RESP with err = 1 and issues no bus access.
  - Any other access goes to BUS_REQ and clears the timeout counter.
- **BUS_REQ**
  - mem_req_valid = 1; the payload is stable until mem_req_ready.
  - On mem_req_ready, go to BUS_RSP.
  - Otherwise the counter increments. When the counter equals TIMEOUT (and TIMEOUT ≠ 0), drop the request and go to RESP with err = 3.
- **BUS_RSP**
  - mem_rsp_ready = 1.
  - On mem_rsp_valid, go to RESP. err = 2 if mem_rsp_err is set, else 0.
  - For a load, extract the byte lane addr[log2(XLEN/8)-1:0] at width 8·2^size, then extend it per req_unsigned.
  - There is no timeout in this state.
- **RESP**
  - rsp_valid = 1; rsp_rdata and rsp_err are held.
  - On rsp_ready, go to IDLE.
- **Store strobes:** 2^size consecutive ones shifted left by the lane offset. wdata is shifted left by 8 × offset.
- **Extension rules**
  - Word loads on XLEN = 64 extend per req_unsigned.
  - On XLEN = 32, loads with size = 2 ignore req_unsigned.
- **Reset**
  - Every output takes its reset value immediately (asynchronously).
  - An in-flight bus transaction is abandoned. The bus and memory side must tolerate mem_req_valid dropping.

## Timing
- **Reset values:** state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_req_valid 0, mem_req_wen 0, mem_req_addr 0, mem_req_wdata 0, mem_req_wstrb 0, mem_rsp_ready 0.
- **Best-case latency:** request accepted at cycle 0; mem_req_valid at cycle 1 (with mem_req_ready = 1); mem_rsp_valid at cycle 2; rsp_valid at cycle 3.
- **Misaligned access:** rsp_valid at cycle 1.
- **Timeout:** err = 3 appears TIMEOUT+1 cycles after request accept.
- **Outstanding requests:** at most one. req_ready = 0 everywhere outside IDLE.
- **Response without bus handshake:** mem_rsp_valid arriving in any state other than BUS_RSP is ignored.
- **No combinational paths:** none from the req_* inputs to the mem_* outputs; all mem_* payload comes from registers.

## Structure
- **Package npc_lsu_pkg** holds:
  - the size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - the error codes (ERR_OK, ERR_MISALIGN, ERR_BUS, ERR_TIMEOUT);
  - the FSM state enum.
- **Sub-module npc_lsu_align** (combinational, parametrised by XLEN) performs:
  - store lane shift and strobe generation;
  - load lane extraction and extension.
- **Top level** holds the FSM, the latched request registers and the timeout counter.

## Test plan
- XLEN = 32, lb at 0x80000003, mem_rsp_rdata 0x80FF1234 -> mem_req_addr 0x80000000, wstrb 0, rsp_rdata 0xFFFFFF80, rsp_err 0, rsp_valid at cycle 3.
- XLEN = 32, sh at 0x80000002, wdata 0x0000ABCD -> mem_req_wdata 0xABCD0000, mem_req_wstrb 0b1100, rsp_rdata 0.
- XLEN = 32, lw at 0x80000001 -> rsp_err 1 at cycle 1, mem_req_valid never asserted; ld on XLEN = 32 -> rsp_err 1.
- TIMEOUT = 4, mem_req_ready held 0 -> mem_req_valid for 4 cycles, then rsp_err 3, then return to IDLE with req_ready 1.
- XLEN = 64, lw (signed) at 0x4, mem_rsp_rdata 0x8000_0001_0000_0000 -> rsp_rdata 0xFFFF_FFFF_8000_0001; the same access with mem_rsp_err = 1 -> rsp_err 2, rdata 0.
- Reset asserted in BUS_RSP and rsp_ready held 0 in RESP for 3 cycles -> all outputs return to reset values immediately; rsp_rdata stays stable until rsp_ready.
